// File: rtl/fifo_addr_gen.sv
// Wrapping address counter used as the read or write pointer of a FIFO.
// Advances by one on each inc, rolling from 2**ADDR_WIDTH-1 back to 0.
module fifo_addr_gen #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] addr
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr <= '0;
        end else if (inc) begin
            addr <= addr + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO: register storage, occupancy count, registered flags,
// registered read port and sticky overflow/underflow flags.
module fifo_sync #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    input  logic                  clr_err,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic                  wr_acc;
    logic                  rd_acc;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [CW-1:0]         count_next;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Acceptance uses only the registered flags, never the raw inputs.
    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    fifo_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
        .clk  (clk),
        .rst  (rst),
        .inc  (wr_acc),
        .addr (wr_addr)
    );

    fifo_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
        .clk  (clk),
        .rst  (rst),
        .inc  (rd_acc),
        .addr (rd_addr)
    );

    always_comb begin
        count_next = count;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count    <= count_next;
            empty    <= (count_next == '0);
            full     <= (count_next == DEPTH_C);
            rd_valid <= rd_acc;
            if (rd_acc) begin
                rd_data <= mem[rd_addr];
            end
            // A new error in the same cycle outranks clr_err.
            if (wr_en && full) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_sync.sv
// Bench for fifo_sync: vector table, directed corner sequences and
// random traffic checked against a queue-based reference model.
module tb_fifo_sync;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          full;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          empty;
    logic [AW:0]   count;
    logic          clr_err;
    logic          overflow;
    logic          underflow;

    int total = 0;
    int bad = 0;

    logic [DW-1:0] q [$];
    logic [DW-1:0] m_rd;
    logic          m_rv;
    logic          m_ovf;
    logic          m_unf;

    typedef struct {
        logic          wr;
        logic [DW-1:0] wd;
        logic          rd;
        logic          clr;
        int            e_count;
        logic          e_full;
        logic          e_empty;
        logic          e_rv;
        logic [DW-1:0] e_rd;
        logic          e_ovf;
        logic          e_unf;
    } vec_t;

    vec_t vecs [$];

    fifo_sync #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .empty     (empty),
        .count     (count),
        .clr_err   (clr_err),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_rd = '0;
        m_rv = 1'b0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // Behavioural model: a plain queue plus sticky bits.
    task automatic model_step(input logic w, input logic [DW-1:0] d,
                              input logic r, input logic c);
        bit was_full;
        bit was_empty;
        was_full = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        m_rv = 1'b0;
        if (r && !was_empty) begin
            m_rd = q.pop_front();
            m_rv = 1'b1;
        end
        if (w && !was_full) q.push_back(d);
        if (w && was_full) m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;
        if (r && was_empty) m_unf = 1'b1;
        else if (c) m_unf = 1'b0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(q.size()));
        chk({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
        chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
        chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(m_rv));
        chk({tag, ".rd_data"}, 32'(rd_data), 32'(m_rd));
        chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
    endtask

    task automatic step(input string tag, input logic w,
                        input logic [DW-1:0] d, input logic r,
                        input logic c);
        wr_en = w;
        wr_data = d;
        rd_en = r;
        clr_err = c;
        @(posedge clk);
        #1;
        model_step(w, d, r, c);
        check_model(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        clr_err = 1'b0;
        wr_data = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    function automatic vec_t mk(input logic w, input logic [DW-1:0] d,
                                input logic r, input logic c, input int ec,
                                input logic ef, input logic ee,
                                input logic erv, input logic [DW-1:0] erd,
                                input logic eo, input logic eu);
        vec_t v;
        v.wr = w; v.wd = d; v.rd = r; v.clr = c;
        v.e_count = ec; v.e_full = ef; v.e_empty = ee;
        v.e_rv = erv; v.e_rd = erd; v.e_ovf = eo; v.e_unf = eu;
        return v;
    endfunction

    initial begin
        logic [DW-1:0] w;
        int n;

        // Vector table: wr wd rd clr | count full empty rv rd ovf unf
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 0, 8'h00, 0, 1));
        vecs.push_back(mk(0, 8'h00, 0, 1, 0, 0, 1, 0, 8'h00, 0, 0));
        vecs.push_back(mk(1, 8'hAA, 1, 0, 1, 0, 0, 0, 8'h00, 0, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 1, 8'hAA, 0, 1));
        vecs.push_back(mk(1, 8'h55, 0, 1, 1, 0, 0, 0, 8'hAA, 0, 0));
        vecs.push_back(mk(1, 8'h66, 1, 0, 1, 0, 0, 1, 8'h55, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 1, 8'h66, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 8'h66, 0, 0));

        do_reset();
        chk("rst.count", 32'(count), 0);
        chk("rst.empty", 32'(empty), 1);
        chk("rst.full", 32'(full), 0);
        chk("rst.rd_valid", 32'(rd_valid), 0);
        chk("rst.overflow", 32'(overflow), 0);
        chk("rst.underflow", 32'(underflow), 0);

        foreach (vecs[i]) begin
            wr_en = vecs[i].wr;
            wr_data = vecs[i].wd;
            rd_en = vecs[i].rd;
            clr_err = vecs[i].clr;
            @(posedge clk);
            #1;
            model_step(vecs[i].wr, vecs[i].wd, vecs[i].rd, vecs[i].clr);
            chk($sformatf("vec%0d.count", i), 32'(count),
                32'(vecs[i].e_count));
            chk($sformatf("vec%0d.full", i), 32'(full), 32'(vecs[i].e_full));
            chk($sformatf("vec%0d.empty", i), 32'(empty),
                32'(vecs[i].e_empty));
            chk($sformatf("vec%0d.rd_valid", i), 32'(rd_valid),
                32'(vecs[i].e_rv));
            chk($sformatf("vec%0d.rd_data", i), 32'(rd_data),
                32'(vecs[i].e_rd));
            chk($sformatf("vec%0d.overflow", i), 32'(overflow),
                32'(vecs[i].e_ovf));
            chk($sformatf("vec%0d.underflow", i), 32'(underflow),
                32'(vecs[i].e_unf));
        end

        // Fill with 0x11..0x1F, 0x10
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            w = 8'h10 | 8'((i + 1) % 16);
            step("fill", 1, w, 0, 0);
        end
        chk("fill.count16", 32'(count), 16);
        chk("fill.full", 32'(full), 1);
        step("ovf", 1, 8'hEE, 0, 0);
        chk("ovf.flag", 32'(overflow), 1);
        chk("ovf.count", 32'(count), 16);

        // Drain in order
        for (int i = 0; i < DEPTH; i++) begin
            step("drain", 0, 8'h00, 1, 0);
            chk("drain.rd_valid", 32'(rd_valid), 1);
            chk("drain.rd_data", 32'(rd_data), 32'(8'h10 | 8'((i + 1) % 16)));
        end
        chk("drain.empty", 32'(empty), 1);
        step("unf", 0, 8'h00, 1, 0);
        chk("unf.flag", 32'(underflow), 1);
        chk("unf.rd_valid", 32'(rd_valid), 0);

        // clr_err with no new error
        step("clr", 0, 8'h00, 0, 1);
        chk("clr.overflow", 32'(overflow), 0);
        chk("clr.underflow", 32'(underflow), 0);

        // Full with simultaneous rd/wr: read wins, write rejected
        for (int i = 0; i < DEPTH; i++) step("refill", 1, 8'(8'h40 + i), 0, 0);
        step("full_rw", 1, 8'hFE, 1, 0);
        chk("full_rw.count", 32'(count), 15);
        chk("full_rw.overflow", 32'(overflow), 1);
        chk("full_rw.rd_data", 32'(rd_data), 32'(8'h40));
        for (int i = 0; i < 7; i++) step("to8", 0, 8'h00, 1, 0);
        chk("to8.count", 32'(count), 8);

        // Streaming at count 8 across pointer wrap
        for (int i = 0; i < 40; i++) begin
            step("stream", 1, 8'(8'h80 + i), 1, 0);
            chk("stream.count", 32'(count), 8);
        end

        // Async reset mid-stream at count 5
        do_reset();
        for (int i = 0; i < 5; i++) step("pre_rst", 1, 8'(8'h30 + i), 0, 0);
        step("pre_rst_rd", 0, 8'h00, 1, 0);
        step("pre_rst_unf", 1, 8'h35, 0, 0);
        chk("pre_rst.count", 32'(count), 5);
        wr_en = 1'b1;
        rd_en = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        chk("arst.count", 32'(count), 0);
        chk("arst.empty", 32'(empty), 1);
        chk("arst.full", 32'(full), 0);
        chk("arst.rd_valid", 32'(rd_valid), 0);
        chk("arst.rd_data", 32'(rd_data), 0);
        chk("arst.overflow", 32'(overflow), 0);
        chk("arst.underflow", 32'(underflow), 0);
        #1;
        rst = 1'b0;
        model_reset();
        step("post_rst", 1, 8'h77, 0, 0);
        step("post_rst_rd", 0, 8'h00, 1, 0);
        chk("post_rst.rd_data", 32'(rd_data), 32'(8'h77));

        // Random traffic against the model
        n = 0;
        for (int i = 0; i < 3000; i++) begin
            logic rw;
            logic rr;
            logic rc;
            int bias;
            bias = (i / 500) % 3;
            rw = ($urandom_range(0, 9) < (bias == 0 ? 7 : (bias == 1 ? 3 : 5)));
            rr = ($urandom_range(0, 9) < (bias == 0 ? 3 : (bias == 1 ? 7 : 5)));
            rc = ($urandom_range(0, 19) == 0);
            step("rand", rw, 8'($urandom), rr, rc);
            n++;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
